// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator between the RV32I execute stage and a word-addressed
//   data memory. It accepts one request at a time and drives only word-aligned
//   addresses. Sub-word stores are done as a read-modify-write. Loads are
//   extracted to byte/half/word and sign- or zero-extended. Misaligned,
//   out-of-range and illegal-funct3 requests fault without touching memory.
//
// Parameters
//   MEM_WORDS : memory depth in 32-bit words; addr[31:2] >= MEM_WORDS faults
//   COUNT_W   : width of the statistics counters
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we, req_funct3  store flag and RV32I width/sign code
//   req_addr, req_wdata byte address and store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/faults)
//   resp_fault          request was rejected
//   mem_address         word-aligned memory address (0 when idle)
//   mem_write_data      full word to write
//   mem_write_enable    single-cycle write strobe
//   mem_read_data       combinational read of mem_address
//
// Optional feature (macro LSU_STATS_EN)
//   Adds saturating counters stat_loads, stat_stores, stat_faults
//   (COUNT_W bits each), incremented in the RESP cycle.

module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_fault,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic                mem_write_enable,
  input  logic [31:0]         mem_read_data
`ifdef LSU_STATS_EN
  ,
  output logic [COUNT_W-1:0]  stat_loads,
  output logic [COUNT_W-1:0]  stat_stores,
  output logic [COUNT_W-1:0]  stat_faults
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        fault_d;
  logic [31:0] load_ext_d;
  logic [31:0] merged_d;

  // Fault decode on the incoming request
  always_comb begin
    logic f3_bad;
    logic mis_half;
    logic mis_word;
    logic out_range;
    if (req_we) begin
      f3_bad = (req_funct3 > 3'd2);
    end else begin
      f3_bad = !((req_funct3 == 3'd0) || (req_funct3 == 3'd1) ||
                 (req_funct3 == 3'd2) || (req_funct3 == 3'd4) ||
                 (req_funct3 == 3'd5));
    end
    mis_half  = (req_funct3[1:0] == 2'd1) && req_addr[0];
    mis_word  = (req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00);
    // Zero-extended compare: no wrap-around for addresses near 2^32
    out_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    fault_d   = f3_bad || mis_half || mis_word || out_range;
  end

  // Load extraction and extension from the live memory read
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    unique case (addr_q[1:0])
      2'd0:    byte_sel = mem_read_data[7:0];
      2'd1:    byte_sel = mem_read_data[15:8];
      2'd2:    byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      3'd0:    load_ext_d = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_ext_d = {24'h000000, byte_sel};
      3'd1:    load_ext_d = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_ext_d = {16'h0000, half_sel};
      default: load_ext_d = mem_read_data;
    endcase
  end

  // Lane merge for SB/SH into the word captured during RMW_RD
  always_comb begin
    merged_d = word_q;
    if (funct3_q[1:0] == 2'd0) begin
      unique case (addr_q[1:0])
        2'd0:    merged_d[7:0]   = wdata_q[7:0];
        2'd1:    merged_d[15:8]  = wdata_q[7:0];
        2'd2:    merged_d[23:16] = wdata_q[7:0];
        default: merged_d[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged_d[31:16] = wdata_q[15:0];
    end else begin
      merged_d[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            fault_q  <= fault_d;
            rdata_q  <= '0;
            if (fault_d)                       state_q <= S_RESP;
            else if (!req_we)                  state_q <= S_LOAD;
            else if (req_funct3[1:0] == 2'd2)  state_q <= S_WRITE;
            else                               state_q <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_ext_d;
          state_q <= S_RESP;
        end
        S_WRITE:  state_q <= S_RESP;
        S_RMW_RD: begin
          word_q  <= mem_read_data;
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: state_q <= S_RESP;
        S_RESP:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded only from registered state so reset clears them at once
  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign resp_fault       = resp_valid && fault_q;
  assign resp_rdata       = resp_valid ? rdata_q : '0;
  assign mem_address      = (state_q == S_IDLE) ? '0 : {addr_q[31:2], 2'b00};
  assign mem_write_enable = (state_q == S_WRITE) || (state_q == S_RMW_WR);
  assign mem_write_data   = (state_q == S_WRITE)  ? wdata_q  :
                            (state_q == S_RMW_WR) ? merged_d : '0;

`ifdef LSU_STATS_EN
  logic [COUNT_W-1:0] loads_q, stores_q, faults_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      faults_q <= '0;
    end else if (state_q == S_RESP) begin
      if (fault_q) begin
        if (faults_q != '1) faults_q <= faults_q + COUNT_W'(1);
      end else if (we_q) begin
        if (stores_q != '1) stores_q <= stores_q + COUNT_W'(1);
      end else begin
        if (loads_q != '1) loads_q <= loads_q + COUNT_W'(1);
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_faults = faults_q;
`else
  // COUNT_W only sizes the statistics counters; this empty guard keeps the
  // parameter referenced when they are compiled out.
  if (COUNT_W == 0) begin : g_count_w_zero
  end
`endif

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the RV32I execute stage and the word-addressed data memory.
- Accepts one load or store request at a time and drives only word-aligned memory addresses.
- Sub-word stores are done as a read-modify-write, because the memory writes only full words.
- Loads are byte/half/word extracted and sign- or zero-extended.
- Misaligned, out-of-range and illegal-funct3 requests are reported as faults and never touch memory.

Parameters:
- MEM_WORDS, 64: depth of the attached memory in 32-bit words; a request faults when its word index (addr[31:2]) is >= MEM_WORDS.
- COUNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle pulse that completes a request.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; request was rejected.
- mem_address  out  32  always {word_index, 2'b00}; 0 when idle.
- mem_write_data  out  32  full word to write.
- mem_write_enable  out  1  single-cycle write strobe.
- mem_read_data  in  32  combinational read of mem_address.

Behaviour:
- Reset (async): state=IDLE; req_ready=1; resp_valid=0, resp_fault=0, resp_rdata=0; mem_address=0, mem_write_data=0, mem_write_enable=0; latched request cleared.
- Outputs are decoded from registered state and latched fields only, so reset forces mem_write_enable low immediately.
- On acceptance, latch we, funct3, addr and wdata, and evaluate the fault condition.
- Fault conditions:
  - funct3 not in {0,1,2,4,5} for loads, or not in {0,1,2} for stores;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- State machine:
  - IDLE -> RESP on a fault (resp_fault=1).
  - IDLE -> LOAD for a load.
  - IDLE -> WRITE for SW.
  - IDLE -> RMW_RD for SB/SH.
  - LOAD: drive mem_address; capture mem_read_data at the edge, extract and extend; -> RESP.
  - WRITE: mem_write_data=wdata, mem_write_enable=1 for exactly this cycle; -> RESP.
  - RMW_RD: drive mem_address; capture the word; -> RMW_WR.
  - RMW_WR: write the captured word with the lane selected by addr[1:0] (byte) or addr[1] (half) replaced; mem_write_enable=1; -> RESP.
  - RESP: resp_valid=1 for one cycle; -> IDLE.
- Latency (accept edge to the cycle resp_valid is high):
  - fault: 1 cycle;
  - LW/LB/LH/LBU/LHU/SW: 2 cycles;
  - SB/SH: 3 cycles.
- Throughput: the next request can be accepted in the cycle after RESP.
- Extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Signed forms replicate bit 7 or bit 15; unsigned forms zero-fill.
- resp_rdata and resp_fault hold their value during RESP and are 0 otherwise.
- Boundary conditions:
  - No response backpressure; the core must consume resp_valid in its cycle.
  - req_valid while busy is ignored (req_ready=0), not queued.
  - Reset in any state aborts the operation; a partially completed RMW leaves memory unmodified because the write only happens in RMW_WR.
  - Address 0xFFFFFFFC with MEM_WORDS=64 faults through the range check, with no wrap-around.

Optional Feature:
- Macro LSU_STATS_EN.
- Defined:
  - Adds outputs stat_loads, stat_stores and stat_faults, each COUNT_W wide.
  - Each counter increments by 1 in the RESP cycle of a completed load, a completed store, or a fault respectively.
  - Counters saturate at all-ones and are cleared by rst_n.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF -> mem_write_enable for one cycle with mem_address 0x10; word 4 = 0xDEADBEEF; resp_valid 2 cycles after accept, resp_fault=0.
2. Word 0x10 = 0x80FF7F01 -> LB 0x13 returns 0xFFFFFF80; LBU 0x13 returns 0x00000080; LH 0x12 returns 0xFFFF80FF; LHU 0x12 returns 0x000080FF; LB 0x10 returns 0x00000001.
3. Word 0x10 = 0xDEADBEEF, SB addr 0x11 data 0x123456AA -> read then write, word = 0xDEADAAEF, resp_valid at 3 cycles; then SH 0x12 data 0x5555 -> 0x5555AAEF.
4. LW 0x12, SH 0x13, and load funct3=3 -> each gives resp_fault=1 at 1 cycle, resp_rdata=0, no mem_write_enable.
5. SW addr 0x100 (word 64, MEM_WORDS=64) -> resp_fault=1, memory unchanged.
6. rst_n low during RMW_RD of SB 0x10 -> mem_write_enable stays 0, outputs reset immediately, word unchanged, req_ready=1 after release; with LSU_STATS_EN, counters read 0.
